z80_io_timer: RTL and testbench
===============================

Name: z80_io_timer

Overview:
- Wishbone I/O-space slave on the z80 core bus. Decodes the core's address, data, strobe and TGA lines.
- Provides a programmable 16-bit down-counter with an 8-bit prescaler and interrupt generation.
- Its interrupt output feeds the core's interrupt request input.
- Returns a programmable mode-2 vector during interrupt-acknowledge cycles.

Parameters:
- BASE_ADR, 8'h40: I/O port base; the block decodes wb_adr_i[7:3] == BASE_ADR[7:3].
- TGA_IO, 2'b01: wb_tga_i code for an I/O cycle.
- TGA_INT, 2'b10: wb_tga_i code for an interrupt-acknowledge cycle.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wb_adr_i  in  16  bus address; only [7:0] are used.
- wb_dat_i  in  8  write data.
- wb_dat_o  out  8  read data; valid when wb_ack_o=1, else 8'h00.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_tga_i  in  2  cycle type.
- wb_ack_o  out  1  acknowledge.
- int_req_o  out  1  interrupt request to the core.

Behaviour:
- Reset (synchronous, active-high): all registers 0, wb_ack_o=0, wb_dat_o=0, int_req_o=0, prescaler=0, count=0.
- Select: sel = cyc & stb & ~ack & ((tga==TGA_IO & adr[7:3] match) | (tga==TGA_INT & int_req_o)).
- Ack: wb_ack_o is registered, asserted for exactly 1 cycle, 1 clock after sel. Held strobe produces alternate-cycle acks; the core drops stb after ack.
- Write effect: applied on the same edge that asserts ack.
- Read data: registered together with ack.
- Register map (adr[2:0]):
  - 0 CTRL: [0] EN, [1] AUTO, [2] IE, [3] LOAD (write-1 pulse, reads 0). Other bits read 0.
  - 1 STAT: [0] PEND (write-1-to-clear), [1] RUN (= EN, read-only).
  - 2 RLD_L, 3 RLD_H: reload value, read/write.
  - 4 CNT_L: read-only, low byte of count.
  - 5 CNT_H: read-only, high byte of count.
  - 6 PSC: prescale; one tick every PSC+1 clocks.
  - 7 VEC: interrupt vector.
- LOAD: count <= {RLD_H,RLD_L}; prescaler <= PSC. Takes effect even if EN is written 0 in the same write.
- Prescaler, while EN=1:
  - prescaler==0: tick asserts for 1 cycle and prescaler <= PSC.
  - otherwise prescaler decrements.
  - While EN=0 the prescaler holds.
- Counter, on tick:
  - count==1 or count==0 is terminal: PEND<=1. Then:
    - AUTO=1: count <= reload. A reload of 0 yields an immediate terminal on the next tick.
    - AUTO=0: count <= 0 and EN <= 0.
  - Otherwise count <= count-1.
- Period: in AUTO mode the period is (PSC+1)*reload clocks for reload >= 1.
- int_req_o = PEND & IE, registered (1-cycle latency from PEND).
- Interrupt ack (tga==TGA_INT, int_req_o=1): wb_dat_o=VEC, ack as above, PEND cleared on the ack edge.
  - If int_req_o=0 the block does not ack; the cycle belongs to another slave.
- Simultaneous events:
  - Terminal tick in the same cycle as a STAT W1C write or an int-ack clear: set wins, PEND stays 1.
  - LOAD in the same cycle as a tick: LOAD wins and the tick is discarded.
  - Write to RLD_H/RLD_L in the same cycle as an AUTO reload: the reload uses the old value.
- Reset mid-cycle: an ack in flight is dropped; the bus master must tolerate this.
- Unselected addresses and memory cycles (tga==2'b00): no ack, no side effects.

Optional Feature:
- Macro: Z80_TIMER_CNT_LATCH_EN.
- Defined: a read of CNT_L captures count[15:8] into a shadow register on the ack edge; CNT_H returns the shadow. This gives an atomic 16-bit read. The shadow resets to 0.
- Undefined: no shadow; CNT_H returns live count[15:8].

Test Plan:
- Reset, then read all 8 ports -> all 8'h00, int_req_o=0. Each ack is 1 cycle wide, 1 clock after stb.
- PSC=3, RLD=16'h0005, CTRL=8'h0F (EN|AUTO|IE|LOAD) -> PEND after 20 clocks. int_req_o rises 1 clock later. Repeats every 20 clocks.
- AUTO=0, RLD=2, PSC=0, EN|LOAD -> one terminal after 2 clocks. EN/RUN reads 0. Count holds 0. No further PEND.
- With int_req_o=1, run a TGA_INT cycle, VEC=8'hA6 -> wb_dat_o=8'hA6 with ack. PEND=0 next cycle. int_req_o drops 1 cycle later.
- Write STAT=8'h01 on the same edge as a terminal tick -> PEND remains 1. Memory-space cycle at adr 16'h0041 -> no ack.
- Z80_TIMER_CNT_LATCH_EN, count=16'h0100: read CNT_L (reads 8'h00), let count decrement, then read CNT_H -> 8'h01. Without the macro, CNT_H -> 8'h00.

Source files
------------

// File: rtl/z80_io_timer.sv
// z80_io_timer -- Wishbone I/O-space timer slave for the z80 core bus.
//
// A 16-bit down-counter clocked by an 8-bit prescaler. It raises an interrupt
// request on terminal count and answers interrupt-acknowledge cycles with a
// programmable mode-2 vector.
//
// Ports:
//   wb_clk_i   clock
//   wb_rst_i   synchronous active-high reset
//   wb_adr_i   bus address; [7:3] selects the block, [2:0] the register
//   wb_dat_i   write data
//   wb_dat_o   registered read data, 8'h00 whenever wb_ack_o is low
//   wb_we_i    write enable
//   wb_cyc_i   bus cycle
//   wb_stb_i   strobe
//   wb_tga_i   cycle type (TGA_IO = I/O, TGA_INT = interrupt acknowledge)
//   wb_ack_o   one-cycle registered acknowledge
//   int_req_o  interrupt request (PEND & IE, registered)
//
// Register map (wb_adr_i[2:0]):
//   0 CTRL  [0] EN, [1] AUTO, [2] IE, [3] LOAD (write-1 pulse, reads 0)
//   1 STAT  [0] PEND (write 1 to clear), [1] RUN (= EN)
//   2 RLD_L, 3 RLD_H   reload value
//   4 CNT_L, 5 CNT_H   counter (read-only)
//   6 PSC   one tick every PSC+1 clocks
//   7 VEC   interrupt-acknowledge vector
//
// Build option: define Z80_TIMER_CNT_LATCH_EN to make a CNT_L read capture
// count[15:8] into a shadow register that CNT_H then returns, giving an
// atomic 16-bit read. Without it CNT_H returns the live high byte.

module z80_io_timer #(
   parameter logic [7:0] BASE_ADR = 8'h40,
   parameter logic [1:0] TGA_IO   = 2'b01,
   parameter logic [1:0] TGA_INT  = 2'b10
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [15:0] wb_adr_i,
   input  logic [7:0]  wb_dat_i,
   output logic [7:0]  wb_dat_o,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic [1:0]  wb_tga_i,
   output logic        wb_ack_o,
   output logic        int_req_o
);

   logic        ack_q, ack_d;
   logic [7:0]  dat_q, dat_d;
   logic        int_q, int_d;
   logic        en_q, en_d;
   logic        auto_q, auto_d;
   logic        ie_q, ie_d;
   logic        pend_q, pend_d;
   logic [15:0] rld_q, rld_d;
   logic [7:0]  psc_q, psc_d;
   logic [7:0]  vec_q, vec_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  pre_q, pre_d;

   logic        sel_io, sel_int, wr, rd, load, tick, term;
   logic [2:0]  reg_adr;
   logic [7:0]  cnt_hi_rd;

   // Only the low address byte is decoded on the I/O space.
   logic        unused_adr;
   assign unused_adr = ^wb_adr_i[15:8];

`ifdef Z80_TIMER_CNT_LATCH_EN
   logic [7:0]  shadow_q, shadow_d;

   always_comb begin
      shadow_d = shadow_q;
      if (rd && reg_adr == 3'd4)
         shadow_d = cnt_q[15:8];
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) shadow_q <= 8'h00;
      else          shadow_q <= shadow_d;
   end

   assign cnt_hi_rd = shadow_q;
`else
   assign cnt_hi_rd = cnt_q[15:8];
`endif

   always_comb begin
      reg_adr = wb_adr_i[2:0];
      // ~ack_q forces a gap after every ack, so a held strobe acks every other cycle.
      sel_io  = wb_cyc_i & wb_stb_i & ~ack_q & (wb_tga_i == TGA_IO)
                & (wb_adr_i[7:3] == BASE_ADR[7:3]);
      // Interrupt acknowledge is only claimed while we are the one requesting.
      sel_int = wb_cyc_i & wb_stb_i & ~ack_q & (wb_tga_i == TGA_INT) & int_q;
      wr      = sel_io & wb_we_i;
      rd      = sel_io & ~wb_we_i;
      load    = wr & (reg_adr == 3'd0) & wb_dat_i[3];
      tick    = en_q & (pre_q == 8'd0);

      ack_d  = sel_io | sel_int;
      dat_d  = 8'h00;
      int_d  = pend_q & ie_q;
      en_d   = en_q;
      auto_d = auto_q;
      ie_d   = ie_q;
      pend_d = pend_q;
      rld_d  = rld_q;
      psc_d  = psc_q;
      vec_d  = vec_q;
      cnt_d  = cnt_q;
      pre_d  = pre_q;
      term   = 1'b0;

      if (sel_int) begin
         dat_d = vec_q;
      end else if (rd) begin
         case (reg_adr)
            3'd0: dat_d = {5'b0, ie_q, auto_q, en_q};
            3'd1: dat_d = {6'b0, en_q, pend_q};
            3'd2: dat_d = rld_q[7:0];
            3'd3: dat_d = rld_q[15:8];
            3'd4: dat_d = cnt_q[7:0];
            3'd5: dat_d = cnt_hi_rd;
            3'd6: dat_d = psc_q;
            3'd7: dat_d = vec_q;
         endcase
      end

      // LOAD overrides any tick in the same cycle; the tick is simply lost.
      if (load) begin
         cnt_d = rld_q;
         pre_d = psc_q;
      end else if (en_q) begin
         pre_d = (pre_q == 8'd0) ? psc_q : pre_q - 8'd1;
         if (tick) begin
            if (cnt_q <= 16'd1) begin
               term = 1'b1;
               if (auto_q) begin
                  cnt_d = rld_q;     // old reload value even if being rewritten now
               end else begin
                  cnt_d = 16'd0;
                  en_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
      end

      if (wr) begin
         case (reg_adr)
            3'd0: begin
               en_d   = wb_dat_i[0];
               auto_d = wb_dat_i[1];
               ie_d   = wb_dat_i[2];
            end
            3'd2: rld_d[7:0]  = wb_dat_i;
            3'd3: rld_d[15:8] = wb_dat_i;
            3'd6: psc_d       = wb_dat_i;
            3'd7: vec_d       = wb_dat_i;
            default: ;
         endcase
      end

      // Clear first so that a terminal count in the same cycle wins.
      if ((wr && reg_adr == 3'd1 && wb_dat_i[0]) || sel_int)
         pend_d = 1'b0;
      if (term)
         pend_d = 1'b1;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q  <= 1'b0;
         dat_q  <= 8'h00;
         int_q  <= 1'b0;
         en_q   <= 1'b0;
         auto_q <= 1'b0;
         ie_q   <= 1'b0;
         pend_q <= 1'b0;
         rld_q  <= 16'h0000;
         psc_q  <= 8'h00;
         vec_q  <= 8'h00;
         cnt_q  <= 16'h0000;
         pre_q  <= 8'h00;
      end else begin
         ack_q  <= ack_d;
         dat_q  <= dat_d;
         int_q  <= int_d;
         en_q   <= en_d;
         auto_q <= auto_d;
         ie_q   <= ie_d;
         pend_q <= pend_d;
         rld_q  <= rld_d;
         psc_q  <= psc_d;
         vec_q  <= vec_d;
         cnt_q  <= cnt_d;
         pre_q  <= pre_d;
      end
   end

   assign wb_ack_o  = ack_q;
   assign wb_dat_o  = dat_q;
   assign int_req_o = int_q;

endmodule

// File: tb/tb_z80_io_timer.sv
// Testbench for z80_io_timer: a vector table for register access and decode,
// hand-written sequences for timing corner cases, and randomized register and
// period checks against a model built from the timer's arithmetic rules.
module tb_z80_io_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] adr;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic        we, cyc, stb, ack, irq;
   logic [1:0]  tga;

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;

   localparam logic [1:0] T_MEM = 2'b00;
   localparam logic [1:0] T_IO  = 2'b01;
   localparam logic [1:0] T_INT = 2'b10;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   z80_io_timer dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb_adr_i (adr),
      .wb_dat_i (din),
      .wb_dat_o (dout),
      .wb_we_i  (we),
      .wb_cyc_i (cyc),
      .wb_stb_i (stb),
      .wb_tga_i (tga),
      .wb_ack_o (ack),
      .int_req_o(irq)
   );

   typedef struct {
      logic [1:0]  tga;
      logic [15:0] adr;
      logic        we;
      logic [7:0]  din;
      logic        exp_ack;
      logic [7:0]  exp_dat;
   } vec_t;

   vec_t tbl[$];
   logic [7:0] model_reg [0:7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One single-strobe bus cycle; returns ack/data sampled just after the edge.
   task automatic bus(input logic [1:0] t, input logic [15:0] a, input logic w,
                      input logic [7:0] d, output logic got_ack,
                      output logic [7:0] got_dat, output int edge_c);
      @(negedge clk);
      tga = t; adr = a; we = w; din = d; cyc = 1'b1; stb = 1'b1;
      @(posedge clk);
      #1;
      edge_c  = cyc_cnt;
      got_ack = ack;
      got_dat = dout;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr_reg(input logic [2:0] r, input logic [7:0] d, output int edge_c);
      logic a;
      logic [7:0] q;
      bus(T_IO, {13'h0008, r}, 1'b1, d, a, q, edge_c);
      check("wr_ack", a, 1'b1);
   endtask

   task automatic rd_reg(input logic [2:0] r, output logic [7:0] q, output int edge_c);
      logic a;
      bus(T_IO, {13'h0008, r}, 1'b0, 8'h00, a, q, edge_c);
      check("rd_ack", a, 1'b1);
   endtask

   task automatic wait_int(input logic level, input int bound, output int at);
      logic done;
      done = 1'b0;
      at = -1;
      for (int k = 0; k < bound && !done; k++) begin
         @(posedge clk);
         #1;
         if (irq === level) begin
            done = 1'b1;
            at = cyc_cnt;
         end
      end
   endtask

   task automatic stop_timer();
      int e, at;
      wr_reg(3'd0, 8'h00, e);
      wr_reg(3'd1, 8'h01, e);
      wait_int(1'b0, 5, at);
      check("stop_int_low", irq, 1'b0);
   endtask

   // AUTO mode: the interrupt rises one clock after each terminal, and
   // terminals fall every (PSC+1)*reload clocks after the LOAD edge.
   task automatic period_test(input logic [7:0] psc, input logic [15:0] rld);
      int e, l, at, p;
      logic [7:0] q;
      p = (int'(psc) + 1) * int'(rld);
      wr_reg(3'd6, psc, e);
      wr_reg(3'd2, rld[7:0], e);
      wr_reg(3'd3, rld[15:8], e);
      wr_reg(3'd0, 8'h0F, l);
      wait_int(1'b1, p + 20, at);
      check("period_rise1", at, l + p + 1);
      rd_reg(3'd1, q, e);
      check("period_stat", q, 8'h03);
      wr_reg(3'd1, 8'h01, e);
      wait_int(1'b0, 10, at);
      wait_int(1'b1, p + 20, at);
      check("period_rise2", at, l + 2 * p + 1);
      $display("period psc=%0d rld=%0d expected=%0d clocks", psc, rld, p);
      stop_timer();
   endtask

   initial begin
      int e, l, at;
      logic a;
      logic [7:0] q;
      logic [7:0] exp_h;
      logic [2:0] ra;
      logic [7:0] rnd_adr;
      logic [2:0] rw_regs [0:3];
      rw_regs[0] = 3'd2; rw_regs[1] = 3'd3; rw_regs[2] = 3'd6; rw_regs[3] = 3'd7;

      rst = 1'b1; adr = 16'h0; din = 8'h0; we = 1'b0; cyc = 1'b0; stb = 1'b0; tga = 2'b00;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_ack", ack, 1'b0);
      check("reset_dat", dout, 8'h00);
      check("reset_int", irq, 1'b0);

      // ---------------- vector table ----------------
      for (int i = 0; i < 8; i++)
         tbl.push_back('{T_IO, 16'h0040 + 16'(i), 1'b0, 8'h00, 1'b1, 8'h00});
      tbl.push_back('{T_MEM, 16'h0041, 1'b0, 8'h00, 1'b0, 8'h00});
      tbl.push_back('{T_IO,  16'h0048, 1'b0, 8'h00, 1'b0, 8'h00});
      tbl.push_back('{T_IO,  16'h0038, 1'b1, 8'hFF, 1'b0, 8'h00});
      tbl.push_back('{T_INT, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00});
      tbl.push_back('{2'b11, 16'h0040, 1'b0, 8'h00, 1'b0, 8'h00});
      tbl.push_back('{T_IO,  16'h0042, 1'b1, 8'h34, 1'b1, 8'h00});
      tbl.push_back('{T_IO,  16'h0043, 1'b1, 8'h12, 1'b1, 8'h00});
      tbl.push_back('{T_IO,  16'h0047, 1'b1, 8'hA6, 1'b1, 8'h00});
      tbl.push_back('{T_IO,  16'h0046, 1'b1, 8'h05, 1'b1, 8'h00});
      tbl.push_back('{T_MEM, 16'h0042, 1'b1, 8'h77, 1'b0, 8'h00});
      tbl.push_back('{T_IO,  16'h0042, 1'b0, 8'h00, 1'b1, 8'h34});
      tbl.push_back('{T_IO,  16'h0043, 1'b0, 8'h00, 1'b1, 8'h12});
      tbl.push_back('{T_IO,  16'hAB47, 1'b0, 8'h00, 1'b1, 8'hA6});
      tbl.push_back('{T_IO,  16'h0046, 1'b0, 8'h00, 1'b1, 8'h05});
      tbl.push_back('{T_IO,  16'h0040, 1'b1, 8'h08, 1'b1, 8'h00});
      tbl.push_back('{T_IO,  16'h0044, 1'b0, 8'h00, 1'b1, 8'h34});
      tbl.push_back('{T_IO,  16'h0045, 1'b0, 8'h00, 1'b1, 8'h12});
      tbl.push_back('{T_IO,  16'h0040, 1'b0, 8'h00, 1'b1, 8'h00});
      tbl.push_back('{T_IO,  16'h0041, 1'b0, 8'h00, 1'b1, 8'h00});
      tbl.push_back('{T_IO,  16'h0040, 1'b1, 8'h06, 1'b1, 8'h00});
      tbl.push_back('{T_IO,  16'h0040, 1'b0, 8'h00, 1'b1, 8'h06});
      tbl.push_back('{T_IO,  16'h0041, 1'b1, 8'h01, 1'b1, 8'h00});
      tbl.push_back('{T_IO,  16'h0040, 1'b1, 8'h00, 1'b1, 8'h00});
      tbl.push_back('{T_IO,  16'h0040, 1'b0, 8'h00, 1'b1, 8'h00});
      tbl.push_back('{T_IO,  16'h0044, 1'b0, 8'h00, 1'b1, 8'h34});

      foreach (tbl[i]) begin
         bus(tbl[i].tga, tbl[i].adr, tbl[i].we, tbl[i].din, a, q, e);
         $display("vec %0d tga=%0b adr=%04h we=%0b din=%02h -> ack=%0b dat=%02h",
                  i, tbl[i].tga, tbl[i].adr, tbl[i].we, tbl[i].din, a, q);
         check($sformatf("vec%0d_ack", i), a, tbl[i].exp_ack);
         if (!tbl[i].we || !tbl[i].exp_ack)
            check($sformatf("vec%0d_dat", i), q, tbl[i].exp_dat);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_ack_width", i), ack, 1'b0);
      end

      // ---------------- held strobe: ack on alternate cycles ----------------
      @(negedge clk);
      tga = T_IO; adr = 16'h0047; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("held_ack%0d", k), ack, (k == 1) ? 1'b0 : 1'b1);
         if (k == 0) check("held_dat", dout, 8'hA6);
      end
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      $display("held strobe on VEC done");

      // ---------------- randomized register model ----------------
      for (int i = 0; i < 8; i++) model_reg[i] = 8'h00;
      model_reg[2] = 8'h34; model_reg[3] = 8'h12; model_reg[6] = 8'h05; model_reg[7] = 8'hA6;
      for (int i = 0; i < 16; i++) begin
         ra = rw_regs[$urandom_range(0, 3)];
         q  = 8'($urandom);
         wr_reg(ra, q, e);
         model_reg[ra] = q;
         // Off-base I/O and non-I/O cycle types must be ignored entirely.
         rnd_adr = 8'($urandom);
         if (rnd_adr[7:3] == 5'b01000) rnd_adr[7] = 1'b1;
         bus(T_IO, {8'($urandom), rnd_adr}, 1'($urandom), 8'($urandom), a, q, e);
         check("rnd_offbase_ack", a, 1'b0);
         bus(($urandom_range(0, 1) == 0) ? T_MEM : 2'b11, {13'h0008, 3'($urandom)},
             1'($urandom), 8'($urandom), a, q, e);
         check("rnd_badtga_ack", a, 1'b0);
         ra = rw_regs[$urandom_range(0, 3)];
         rd_reg(ra, q, e);
         $display("rnd %0d reg %0d read %02h model %02h", i, ra, q, model_reg[ra]);
         check("rnd_reg", q, model_reg[ra]);
      end
      for (int r = 0; r < 8; r++) begin
         if (r == 2 || r == 3 || r == 6 || r == 7) begin
            rd_reg(3'(r), q, e);
            check("rnd_final", q, model_reg[r]);
         end
      end
      rd_reg(3'd0, q, e);
      check("rnd_ctrl_idle", q, 8'h00);
      rd_reg(3'd1, q, e);
      check("rnd_stat_idle", q, 8'h00);

      // ---------------- AUTO period ----------------
      period_test(8'd3, 16'd5);
      for (int i = 0; i < 4; i++)
         period_test(8'($urandom_range(0, 3)), 16'($urandom_range(6, 12)));

      // ---------------- one-shot ----------------
      wr_reg(3'd7, 8'hA6, e);
      wr_reg(3'd6, 8'h00, e);
      wr_reg(3'd2, 8'h02, e);
      wr_reg(3'd3, 8'h00, e);
      wr_reg(3'd0, 8'h0D, l);
      wait_int(1'b1, 20, at);
      check("oneshot_rise", at, l + 3);
      rd_reg(3'd0, q, e);
      check("oneshot_ctrl", q, 8'h04);
      rd_reg(3'd1, q, e);
      check("oneshot_stat", q, 8'h01);
      rd_reg(3'd4, q, e);
      check("oneshot_cnt_l", q, 8'h00);
      rd_reg(3'd5, q, e);
      check("oneshot_cnt_h", q, 8'h00);

      // ---------------- interrupt acknowledge ----------------
      bus(T_INT, 16'h0000, 1'b0, 8'h00, a, q, e);
      $display("intack ack=%0b vec=%02h", a, q);
      check("intack_ack", a, 1'b1);
      check("intack_vec", q, 8'hA6);
      check("intack_int_hold", irq, 1'b1);
      @(posedge clk);
      #1;
      check("intack_int_drop", irq, 1'b0);
      rd_reg(3'd1, q, e);
      check("intack_stat", q, 8'h00);
      bus(T_INT, 16'h0000, 1'b0, 8'h00, a, q, e);
      check("intack_noint_ack", a, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      check("oneshot_no_more_int", irq, 1'b0);
      rd_reg(3'd1, q, e);
      check("oneshot_no_more_pend", q, 8'h00);
      stop_timer();

      // ---------------- terminal tick vs STAT clear ----------------
      wr_reg(3'd2, 8'h02, e);
      wr_reg(3'd0, 8'h0B, l);
      wr_reg(3'd1, 8'h01, e);   // lands on the terminal edge l+2
      check("setwins_edge", e, l + 2);
      rd_reg(3'd1, q, e);
      check("setwins_stat", q, 8'h03);
      stop_timer();
      wr_reg(3'd2, 8'h03, e);
      wr_reg(3'd0, 8'h0B, l);
      rd_reg(3'd1, q, e);
      check("clear_pre_stat", q, 8'h02);
      wr_reg(3'd1, 8'h01, e);   // terminal was at l+3, none at l+4
      rd_reg(3'd1, q, e);
      check("clear_stat", q, 8'h02);
      stop_timer();

      // ---------------- CNT_H shadow ----------------
      wr_reg(3'd2, 8'h00, e);
      wr_reg(3'd3, 8'h01, e);
      wr_reg(3'd6, 8'h00, e);
      wr_reg(3'd0, 8'h08, l);
      rd_reg(3'd4, q, e);
      check("latch_cnt_l", q, 8'h00);
      wr_reg(3'd0, 8'h01, e);
      rd_reg(3'd5, q, e);
`ifdef Z80_TIMER_CNT_LATCH_EN
      exp_h = 8'h01;
`else
      exp_h = 8'h00;
`endif
      $display("cnt_h after decrement read %02h", q);
      check("latch_cnt_h", q, exp_h);
      stop_timer();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
